// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store initiator: turns byte-addressed requests into word-indexed memory
// accesses, extends sub-word loads and performs SB/SH as read-modify-write.
module mem_access_ctrl #(
  parameter int DEPTH = 42,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic          req_store,
  input  logic [1:0]    req_size,
  input  logic          req_uns,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  output logic          ready,
  output logic          done,
  output logic          err,
  output logic [31:0]   rdata,
  output logic          mem_we,
  output logic          mem_read,
  output logic [31:0]   mem_addr,
  output logic [31:0]   mem_wd,
  input  logic [31:0]   mem_rd
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_LRESP = 3'd2,
    S_MERGE = 3'd3,
    S_WRITE = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  localparam logic [AW-3:0] LP_DEPTH = (AW-2)'(DEPTH);

  state_t        r_state;
  state_t        w_next;
  logic [AW-1:0] r_addr;
  logic [1:0]    r_size;
  logic          r_store;
  logic          r_uns;
  logic [31:0]   r_wdata;
  logic          w_accept;
  logic          w_bad;

  // Selects the addressed byte/half of a memory word and sign- or zero-extends it.
  function automatic logic [31:0] f_load_ext(input logic [31:0] word, input logic [1:0] size,
                                             input logic [1:0] off, input logic uns);
    logic [31:0] v_sh;
    logic [15:0] v_h;
    v_sh = word >> {off, 3'b000};
    v_h  = off[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   f_load_ext = uns ? {24'h000000, v_sh[7:0]} : {{24{v_sh[7]}}, v_sh[7:0]};
      2'b01:   f_load_ext = uns ? {16'h0000, v_h} : {{16{v_h[15]}}, v_h};
      default: f_load_ext = word;
    endcase
  endfunction

  // Replaces the addressed byte/half of the old word with the low bits of the store data.
  function automatic logic [31:0] f_merge(input logic [31:0] word, input logic [31:0] wd,
                                          input logic [1:0] size, input logic [1:0] off);
    logic [31:0] v_m;
    logic [31:0] v_d;
    case (size)
      2'b00: begin
        v_m = 32'h000000FF << {off, 3'b000};
        v_d = {24'h000000, wd[7:0]} << {off, 3'b000};
      end
      2'b01: begin
        v_m = 32'h0000FFFF << {off[1], 4'b0000};
        v_d = {16'h0000, wd[15:0]} << {off[1], 4'b0000};
      end
      default: begin
        v_m = 32'hFFFFFFFF;
        v_d = wd;
      end
    endcase
    f_merge = (word & ~v_m) | (v_d & v_m);
  endfunction

  assign w_accept = (r_state == S_IDLE) && req;
  assign w_bad    = (req_size == 2'b11) ||
                    ((req_size == 2'b01) && req_addr[0]) ||
                    ((req_size == 2'b10) && (req_addr[1:0] != 2'b00)) ||
                    (req_addr[AW-1:2] >= LP_DEPTH);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Request latch, captured only on accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr  <= '0;
      r_size  <= 2'b00;
      r_store <= 1'b0;
      r_uns   <= 1'b0;
      r_wdata <= 32'h00000000;
    end else if (w_accept) begin
      r_addr  <= req_addr;
      r_size  <= req_size;
      r_store <= req_store;
      r_uns   <= req_uns;
      r_wdata <= req_wdata;
    end else begin
      r_addr  <= r_addr;
      r_size  <= r_size;
      r_store <= r_store;
      r_uns   <= r_uns;
      r_wdata <= r_wdata;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE: begin
        if (!req)                                  w_next = S_IDLE;
        else if (w_bad)                            w_next = S_ERR;
        else if (req_store && req_size == 2'b10)   w_next = S_WRITE;
        else                                       w_next = S_READ;
      end
      S_READ:  w_next = r_store ? S_MERGE : S_LRESP;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs decoded from registered state and latched request only.
  always_comb begin
    ready    = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    rdata    = 32'h00000000;
    mem_we   = 1'b0;
    mem_read = 1'b0;
    mem_addr = 32'h00000000;
    mem_wd   = 32'h00000000;
    case (r_state)
      S_IDLE:  ready = 1'b1;
      S_READ: begin
        mem_read = 1'b1;
        mem_addr = 32'(r_addr[AW-1:2]);
      end
      S_LRESP: begin
        done  = 1'b1;
        rdata = f_load_ext(mem_rd, r_size, r_addr[1:0], r_uns);
      end
      S_MERGE: begin
        mem_we   = 1'b1;
        mem_addr = 32'(r_addr[AW-1:2]);
        mem_wd   = f_merge(mem_rd, r_wdata, r_size, r_addr[1:0]);
        done     = 1'b1;
      end
      S_WRITE: begin
        mem_we   = 1'b1;
        mem_addr = 32'(r_addr[AW-1:2]);
        mem_wd   = r_wdata;
        done     = 1'b1;
      end
      S_ERR: begin
        done = 1'b1;
        err  = 1'b1;
      end
      default: ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized scoreboard bench for mem_access_ctrl: a byte-array reference model predicts
// every response, a monitor process checks each done pulse against the queue.
module tb_mem_access_ctrl;
  localparam int DEPTH = 42;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic        req_store = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_uns = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        ready, done, err, mem_we, mem_read;
  logic [31:0] rdata, mem_addr, mem_wd;
  logic [31:0] mem_rd = 32'h0;

  mem_access_ctrl #(.DEPTH(DEPTH), .AW(32)) dut (
    .clk(clk), .reset(reset), .req(req), .req_store(req_store), .req_size(req_size),
    .req_uns(req_uns), .req_addr(req_addr), .req_wdata(req_wdata), .ready(ready),
    .done(done), .err(err), .rdata(rdata), .mem_we(mem_we), .mem_read(mem_read),
    .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  // Data memory device: registered read, write on the clock edge.
  logic [31:0] tb_mem [0:DEPTH-1];
  logic        preload = 1'b1;
  int          wr_count = 0;
  int          cyc = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (preload) begin
      for (int k = 0; k < DEPTH; k++) tb_mem[k] <= 32'(k);
    end else begin
      if (mem_we) begin
        wr_count <= wr_count + 1;
        if (mem_addr < 32'(DEPTH)) tb_mem[mem_addr] <= mem_wd;
      end
      if (mem_read) mem_rd <= (mem_addr < 32'(DEPTH)) ? tb_mem[mem_addr] : 32'hX;
    end
  end

  typedef struct {
    logic        err;
    logic        is_load;
    logic [31:0] rdata;
    int          due;
  } exp_t;

  exp_t        sb [$];
  logic [7:0]  ref_bytes [0:DEPTH*4-1];
  int          checks = 0;
  int          errors = 0;
  int          both_active = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, req_v, cyc);
    end
  endtask

  task automatic monitor();
    exp_t e;
    logic prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_done = 1'b0;
        continue;
      end
      if (mem_we && mem_read) both_active++;
      if (prev_done) check("ready_after_done", {31'h0, ready}, 32'h1);
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 32'h1, 32'h0);
        end else begin
          e = sb.pop_front();
          check("err", {31'h0, err}, {31'h0, e.err});
          check("rdata", rdata, (e.is_load && !e.err) ? e.rdata : 32'h0);
          check("latency_cycle", 32'(cyc), 32'(e.due));
        end
      end
      prev_done = done;
    end
  endtask

  // Reference: byte-addressed little-endian memory, evaluated per request.
  task automatic ref_access(input bit st, input int size, input bit uns, input int addr,
                            input logic [31:0] wd, output exp_t e);
    int n;
    int idx;
    logic [31:0] v;
    n   = 1 << size;
    idx = addr / 4;
    e.is_load = !st;
    e.rdata   = 32'h0;
    e.err     = (size == 3) || (addr % n != 0) || (idx >= DEPTH);
    if (e.err) begin
      e.due = cyc + 1;
    end else if (st) begin
      for (int i = 0; i < n; i++) ref_bytes[addr + i] = wd[8*i +: 8];
      e.due = cyc + ((size == 2) ? 1 : 2);
    end else begin
      v = 32'h0;
      for (int i = 0; i < n; i++) v = v | (32'(ref_bytes[addr + i]) << (8 * i));
      if (!uns && n < 4 && v[8*n-1]) v = v - (32'd1 << (8 * n));
      e.rdata = v;
      e.due = cyc + 2;
    end
  endtask

  task automatic do_req(input bit st, input int size, input bit uns, input int addr,
                        input logic [31:0] wd);
    exp_t e;
    int n;
    @(negedge clk);
    n = 0;
    while (!ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      check("ready_timeout", 32'h0, 32'h1);
      return;
    end
    req = 1'b1; req_store = st; req_size = 2'(size); req_uns = uns;
    req_addr = 32'(addr); req_wdata = wd;
    ref_access(st, size, uns, addr, wd, e);
    sb.push_back(e);
    @(posedge clk);
    #1;
    req = 1'b0;
    req_wdata = $urandom;
    req_addr = $urandom;
  endtask

  initial begin
    int w0;
    for (int k = 0; k < DEPTH * 4; k++) ref_bytes[k] = (k % 4 == 0) ? 8'(k / 4) : 8'h00;
    repeat (3) @(negedge clk);
    preload = 1'b0;
    reset = 1'b0;
    fork monitor(); join_none
    check("reset_ready", {31'h0, ready}, 32'h1);
    check("reset_outs", {26'h0, done, err, mem_we, mem_read, 2'b00} | rdata | mem_addr | mem_wd,
          32'h0);

    // SH 0x08 aborted by reset while in READ.
    w0 = wr_count;
    req = 1'b1; req_store = 1'b1; req_size = 2'b01; req_uns = 1'b0;
    req_addr = 32'h08; req_wdata = 32'h1234BEEF;
    @(posedge clk); #1; req = 1'b0;
    @(negedge clk);
    check("abort_in_read", {31'h0, mem_read}, 32'h1);
    reset = 1'b1;
    #1;
    check("abort_ready", {31'h0, ready}, 32'h1);
    check("abort_outs", {26'h0, done, err, mem_we, mem_read, 2'b00} | rdata | mem_addr | mem_wd,
          32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("abort_no_write", 32'(wr_count - w0), 32'h0);
    check("abort_mem2", tb_mem[2], 32'h2);

    do_req(1'b0, 2, 1'b0, 32'h14, 32'h0);
    do_req(1'b1, 0, 1'b0, 32'h0D, 32'h000000AB);
    do_req(1'b0, 0, 1'b0, 32'h0D, 32'h0);
    do_req(1'b0, 0, 1'b1, 32'h0D, 32'h0);
    do_req(1'b0, 1, 1'b0, 32'h0C, 32'h0);
    do_req(1'b0, 1, 1'b1, 32'h0C, 32'h0);
    w0 = wr_count;
    do_req(1'b1, 1, 1'b0, 32'h05, 32'hFFFF5555);
    do_req(1'b0, 2, 1'b0, 32'hA8, 32'h0);
    do_req(1'b1, 2, 1'b0, 32'hA8, 32'h11111111);
    repeat (3) @(negedge clk);
    check("err_no_write", 32'(wr_count - w0), 32'h0);
    do_req(1'b1, 2, 1'b0, 32'h10, 32'hDEADBEEF);
    repeat (3) @(negedge clk);
    check("sw_mem4", tb_mem[4], 32'hDEADBEEF);
    do_req(1'b0, 2, 1'b0, 32'h10, 32'h0);

    for (int i = 0; i < 250; i++) begin
      do_req(1'($urandom), int'($urandom_range(0, 3)), 1'($urandom),
             int'($urandom_range(0, DEPTH * 4 + 11)), $urandom);
    end

    for (int t = 0; t < 10 && sb.size() != 0; t++) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'h0);
    repeat (2) @(negedge clk);
    for (int k = 0; k < DEPTH; k++) begin
      check($sformatf("mem_word_%0d", k), tb_mem[k],
            {ref_bytes[4*k+3], ref_bytes[4*k+2], ref_bytes[4*k+1], ref_bytes[4*k]});
    end
    check("we_read_exclusive", 32'(both_active), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
